dca_product_accumulator: RTL and testbench



---
 rtl/dca_product_accumulator_if.sv | 22 ++
 rtl/dca_product_accumulator.sv | 153 +++++++++++++++
 tb/tb_dca_product_accumulator.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dca_product_accumulator_if.sv
// Product stream in, result stream out for the product accumulator.
// Master drives products and consumer ready; slave returns queued results.
interface dca_product_accumulator_if #(
  parameter int BW_PRODUCT = 32,
  parameter int BW_RESULT  = 32
);
  logic                  in_valid;
  logic [BW_PRODUCT-1:0] in_product;
  logic                  out_valid;
  logic                  out_ready;
  logic [BW_RESULT-1:0]  out_result;

  modport master (
    output in_valid, in_product, out_ready,
    input  out_valid, out_result
  );

  modport slave (
    input  in_valid, in_product, out_ready,
    output out_valid, out_result
  );
endinterface

// File: rtl/dca_product_accumulator.sv
// Windowed product accumulator: sum, shift, saturate, queue.
// Completed windows that find the output FIFO full are dropped and flagged.
module dca_product_accumulator #(
  parameter int BW_PRODUCT = 32,
  parameter int BW_ACC     = 48,
  parameter int BW_RESULT  = 32,
  parameter int BW_COUNT   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rstnn,
  input  logic                enable,
  input  logic                clear,
  input  logic [BW_COUNT-1:0] cfg_length,
  input  logic [5:0]          cfg_shift,
  output logic                busy,
  output logic                overflow,
  dca_product_accumulator_if.slave bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [BW_COUNT-1:0] ONE = BW_COUNT'(1);
  localparam logic [PW-1:0] PONE = PW'(1);
  localparam logic [PW:0] OONE = (PW+1)'(1);
  localparam logic [PW:0] DEPTH = (PW+1)'(FIFO_DEPTH);
  localparam logic signed [BW_ACC-1:0] RMAX =
    {{(BW_ACC-BW_RESULT+1){1'b0}}, {(BW_RESULT-1){1'b1}}};
  localparam logic signed [BW_ACC-1:0] RMIN =
    {{(BW_ACC-BW_RESULT+1){1'b1}}, {(BW_RESULT-1){1'b0}}};

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                state_q, state_d;
  logic [BW_ACC-1:0]     acc_q, acc_d;
  logic [BW_COUNT-1:0]   cnt_q, cnt_d;
  logic [BW_COUNT-1:0]   len_q, len_d;
  logic [BW_RESULT-1:0]  mem_q [FIFO_DEPTH];
  logic [BW_RESULT-1:0]  mem_d [FIFO_DEPTH];
  logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]           occ_q, occ_d;
  logic [BW_RESULT-1:0]  hold_q, hold_d;
  logic                  ovf_q, ovf_d;

  logic [BW_COUNT-1:0]   len_cfg, len_cur;
  logic [BW_ACC-1:0]     sum;
  logic signed [BW_ACC-1:0] shr;
  logic [BW_RESULT-1:0]  res;
  logic                  last, push, pop, wr_en;
  logic                  full, empty;

  // The window length is only sampled on the first product of a window.
  assign len_cfg = (cfg_length == '0) ? ONE : cfg_length;
  assign len_cur = (state_q == IDLE) ? len_cfg : len_q;
  assign last    = (cnt_q == len_cur - ONE);

  assign sum = acc_q + {{(BW_ACC-BW_PRODUCT){bus.in_product[BW_PRODUCT-1]}},
                        bus.in_product};
  assign shr = $signed(sum) >>> cfg_shift;

  always_comb begin
    res = shr[BW_RESULT-1:0];
    if (shr > RMAX) res = RMAX[BW_RESULT-1:0];
    else if (shr < RMIN) res = RMIN[BW_RESULT-1:0];
  end

  assign full  = (occ_q == DEPTH);
  assign empty = (occ_q == '0);
  assign push  = enable & ~clear & bus.in_valid & last;
  assign pop   = enable & ~clear & ~empty & bus.out_ready;
  assign wr_en = push & (~full | pop);

  assign bus.out_valid  = ~empty;
  assign bus.out_result = empty ? hold_q : mem_q[rd_q];
  assign busy           = (state_q == ACCUM);
  assign overflow       = ovf_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    occ_d   = occ_q;
    hold_d  = hold_q;
    ovf_d   = ovf_q;
    if (enable && clear) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      wr_d    = '0;
      rd_d    = '0;
      occ_d   = '0;
      hold_d  = '0;
      ovf_d   = 1'b0;
    end else if (enable) begin
      if (bus.in_valid) begin
        if (state_q == IDLE) len_d = len_cfg;
        if (last) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          acc_d   = sum;
          cnt_d   = cnt_q + ONE;
          state_d = ACCUM;
        end
      end
      if (pop) begin
        hold_d = mem_q[rd_q];
        rd_d   = rd_q + PONE;
      end
      if (wr_en) begin
        mem_d[wr_q] = res;
        wr_d        = wr_q + PONE;
      end
      if (push && !wr_en) ovf_d = 1'b1;
      unique case ({wr_en, pop})
        2'b10:   occ_d = occ_q + OONE;
        2'b01:   occ_d = occ_q - OONE;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= ONE;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      occ_q   <= '0;
      hold_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      occ_q   <= occ_d;
      hold_q  <= hold_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_dca_product_accumulator.sv
// Bench for dca_product_accumulator: directed scenarios plus a
// randomized run against a list-based window/queue reference model.
module tb_dca_product_accumulator;

  logic        clk = 1'b0;
  logic        rstnn = 1'b0;
  logic        enable = 1'b1;
  logic        clear = 1'b0;
  logic [15:0] cfg_length = 16'd1;
  logic [5:0]  cfg_shift = 6'd0;
  logic        busy, overflow;

  int n_chk = 0;
  int n_fail = 0;

  dca_product_accumulator_if #(.BW_PRODUCT(32), .BW_RESULT(32)) bus ();

  dca_product_accumulator dut (
    .clk(clk), .rstnn(rstnn), .enable(enable), .clear(clear),
    .cfg_length(cfg_length), .cfg_shift(cfg_shift),
    .busy(busy), .overflow(overflow), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] p);
    bus.in_valid = 1'b1;
    bus.in_product = p;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic pop1();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Floor shift of the exact sum, then clamp to the 32-bit signed range.
  function automatic logic [31:0] ref_res(input longint s, input int sh);
    longint r;
    r = (sh >= 48) ? ((s < 0) ? -64'sd1 : 64'sd0) : (s >>> sh);
    if (r > 64'sd2147483647) r = 64'sd2147483647;
    if (r < -64'sd2147483648) r = -64'sd2147483648;
    return r[31:0];
  endfunction

  task automatic test_reset();
    rstnn = 1'b0;
    #12;
    n_chk++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags got v=%b b=%b o=%b want 0 0 0",
               bus.out_valid, busy, overflow);
    end
    n_chk++;
    if (bus.out_result !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_result got %h want 0", bus.out_result);
    end
    rstnn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [31:0] ps [4];
    ps[0] = 32'd3; ps[1] = -32'sd5; ps[2] = 32'd10; ps[3] = 32'd7;
    cfg_length = 16'd4;
    cfg_shift = 6'd0;
    for (int i = 0; i < 3; i++) begin
      send(ps[i]);
      n_chk++;
      if (busy !== 1'b1 || bus.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_busy%0d got b=%b v=%b want 1 0",
                 i, busy, bus.out_valid);
      end
    end
    send(ps[3]);
    n_chk++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd15 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result got v=%b r=%0d b=%b want 1 15 0",
               bus.out_valid, $signed(bus.out_result), busy);
    end
    pop1();
    n_chk++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_pop got v=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_shift_sat();
    logic [31:0] pa [4];
    logic [5:0]  sa [4];
    logic [31:0] ea [4];
    pa[0] = 32'h7FFFFFFF; sa[0] = 6'd4;  ea[0] = 32'h0FFFFFFF;
    pa[1] = 32'h7FFFFFFF; sa[1] = 6'd0;  ea[1] = 32'h7FFFFFFF;
    pa[2] = 32'h80000000; sa[2] = 6'd0;  ea[2] = 32'h80000000;
    pa[3] = 32'h80000000; sa[3] = 6'd60; ea[3] = 32'hFFFFFFFF;
    cfg_length = 16'd2;
    for (int i = 0; i < 4; i++) begin
      cfg_shift = sa[i];
      send(pa[i]);
      send(pa[i]);
      n_chk++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== ea[i]) begin
        n_fail++;
        $display("FAIL shift_sat%0d got v=%b r=%h want 1 %h",
                 i, bus.out_valid, bus.out_result, ea[i]);
      end
      pop1();
    end
    cfg_shift = 6'd0;
  endtask

  task automatic test_length();
    cfg_length = 16'd0;
    send(32'd9);
    n_chk++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd9 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL len0_first got v=%b r=%0d b=%b want 1 9 0",
               bus.out_valid, bus.out_result, busy);
    end
    send(32'hFFFFFFFF);
    pop1();
    n_chk++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 32'hFFFFFFFF) begin
      n_fail++;
      $display("FAIL len0_second got v=%b r=%h want 1 ffffffff",
               bus.out_valid, bus.out_result);
    end
    pop1();
    cfg_length = 16'd3;
    send(32'd1);
    cfg_length = 16'd2;
    send(32'd2);
    n_chk++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL len_latch_mid got v=%b b=%b want 0 1",
               bus.out_valid, busy);
    end
    send(32'd4);
    n_chk++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd7) begin
      n_fail++;
      $display("FAIL len_latch_sum got v=%b r=%0d want 1 7",
               bus.out_valid, bus.out_result);
    end
    pop1();
  endtask

  task automatic test_overflow();
    do_clear();
    cfg_length = 16'd1;
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      bus.in_valid = 1'b1;
      bus.in_product = 32'(k);
      tick();
    end
    bus.in_valid = 1'b0;
    n_chk++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set got %b want 1", overflow);
    end
    for (int k = 1; k <= 4; k++) begin
      n_chk++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== 32'(k)) begin
        n_fail++;
        $display("FAIL ovf_drain%0d got v=%b r=%0d want 1 %0d",
                 k, bus.out_valid, bus.out_result, k);
      end
      pop1();
    end
    n_chk++;
    if (bus.out_valid !== 1'b0 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky got v=%b o=%b want 0 1",
               bus.out_valid, overflow);
    end
    do_clear();
    for (int k = 1; k <= 5; k++) begin
      bus.in_valid = 1'b1;
      bus.in_product = 32'(k);
      bus.out_ready = (k == 5);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    n_chk++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_pushpop got %b want 0", overflow);
    end
    for (int k = 2; k <= 5; k++) begin
      n_chk++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== 32'(k)) begin
        n_fail++;
        $display("FAIL pushpop_drain%0d got v=%b r=%0d want 1 %0d",
                 k, bus.out_valid, bus.out_result, k);
      end
      pop1();
    end
  endtask

  task automatic test_enable_clear();
    do_clear();
    cfg_length = 16'd3;
    send(32'd10);
    enable = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_product = 32'd100;
    tick();
    tick();
    bus.in_valid = 1'b0;
    enable = 1'b1;
    n_chk++;
    if (busy !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL en_hold got b=%b v=%b want 1 0", busy, bus.out_valid);
    end
    send(32'd20);
    send(32'd30);
    n_chk++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd60) begin
      n_fail++;
      $display("FAIL en_resume got v=%b r=%0d want 1 60",
               bus.out_valid, bus.out_result);
    end
    cfg_length = 16'd1;
    for (int k = 1; k <= 4; k++) send(32'(k));
    enable = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    enable = 1'b1;
    n_chk++;
    if (overflow !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_result !== 32'd60) begin
      n_fail++;
      $display("FAIL en_nopop got o=%b v=%b r=%0d want 1 1 60",
               overflow, bus.out_valid, bus.out_result);
    end
    cfg_length = 16'd2;
    send(32'd50);
    do_clear();
    n_chk++;
    if (bus.out_valid !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_state got v=%b o=%b b=%b want 0 0 0",
               bus.out_valid, overflow, busy);
    end
    send(32'd1);
    send(32'd2);
    n_chk++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd3) begin
      n_fail++;
      $display("FAIL clear_acc got v=%b r=%0d want 1 3",
               bus.out_valid, bus.out_result);
    end
    pop1();
  endtask

  task automatic test_async_reset();
    cfg_length = 16'd1;
    send(32'd8);
    cfg_length = 16'd4;
    send(32'd1);
    send(32'd2);
    #2;
    rstnn = 1'b0;
    #1;
    n_chk++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0 ||
        bus.out_result !== 32'd0) begin
      n_fail++;
      $display("FAIL async_rst got v=%b b=%b o=%b r=%0d want 0 0 0 0",
               bus.out_valid, busy, overflow, bus.out_result);
    end
    #2;
    rstnn = 1'b1;
    tick();
    for (int k = 1; k <= 4; k++) send(32'(k));
    n_chk++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd10) begin
      n_fail++;
      $display("FAIL async_fresh got v=%b r=%0d want 1 10",
               bus.out_valid, bus.out_result);
    end
    pop1();
  endtask

  task automatic test_random();
    longint      msum = 0;
    int          mcnt = 0;
    int          mlen = 1;
    bit          movf = 1'b0;
    logic [31:0] q [$];
    bit          full, pop, push;
    logic [31:0] val;
    do_clear();
    for (int c = 0; c < 400; c++) begin
      enable = ($urandom_range(0, 9) != 0);
      bus.in_valid = ($urandom_range(0, 9) < 7);
      bus.in_product = $urandom;
      bus.out_ready = $urandom_range(0, 1);
      cfg_length = 16'($urandom_range(0, 4));
      cfg_shift = 6'($urandom_range(0, 52));
      if (enable) begin
        full = (q.size() == 4);
        pop = (q.size() > 0) && bus.out_ready;
        push = 1'b0;
        val = '0;
        if (bus.in_valid) begin
          if (mcnt == 0) mlen = (cfg_length == 0) ? 1 : int'(cfg_length);
          msum += longint'($signed(bus.in_product));
          mcnt++;
          if (mcnt == mlen) begin
            push = 1'b1;
            val = ref_res(msum, int'(cfg_shift));
            msum = 0;
            mcnt = 0;
          end
        end
        if (pop) void'(q.pop_front());
        if (push) begin
          if (!full || pop) q.push_back(val);
          else movf = 1'b1;
        end
      end
      tick();
      n_chk++;
      if (bus.out_valid !== (q.size() != 0) || busy !== (mcnt != 0) ||
          overflow !== movf) begin
        n_fail++;
        $display("FAIL rand_flags c=%0d got v=%b b=%b o=%b want %b %b %b",
                 c, bus.out_valid, busy, overflow,
                 q.size() != 0, mcnt != 0, movf);
      end
      if (q.size() != 0) begin
        n_chk++;
        if (bus.out_result !== q[0]) begin
          n_fail++;
          $display("FAIL rand_result c=%0d got %h want %h",
                   c, bus.out_result, q[0]);
        end
      end
    end
    enable = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_product = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_shift_sat();
    test_length();
    test_overflow();
    test_enable_clear();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
